game_io_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the processor register file and the arcade game hardware. It replaces hard-wired I/O registers such as r20/r22 and the button, screen, collision and pause signals. It provides:
- atomic snapshots of game-state inputs;
- sticky, synchronised event flags with overflow detection and an interrupt line;
- double-buffered output registers that reach the game hardware only on a frame commit.

It sits beside `regfile`, snooping its write port and answering its read ports for mapped register numbers.

---
 rtl/game_io_bridge_pkg.sv | 33 +++
 rtl/game_io_bridge_if.sv | 49 ++++
 rtl/game_io_bridge_evt_sync_edge.sv | 43 ++++
 rtl/game_io_bridge.sv | 189 ++++++++++++++++++
 tb/tb_game_io_bridge.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/game_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_bridge_pkg
// Description : Shared constants and helpers for the game I/O bridge:
//               control/status bit positions and default register numbers.
// Revision    : 1.0 - initial release
// ============================================================================
package io_bridge_pkg;

    // Control register bit positions
    localparam int c_CTRL_SNAP     = 0;
    localparam int c_CTRL_COMMIT   = 1;
    localparam int c_CTRL_DIRTY    = 2;
    localparam int c_CTRL_MASK_LSB = 8;

    // Event status register: overflow flags start at this bit
    localparam int c_EVT_OVF_LSB   = 16;

    // Default register numbers in the processor register file
    localparam int c_DEF_IN_BASE   = 20;
    localparam int c_DEF_OUT_BASE  = 14;
    localparam int c_DEF_EVT_REG   = 24;
    localparam int c_DEF_CTRL_REG  = 25;

    // True when addr falls in [base, base+n) and is not register 0
    function automatic logic reg_in_range(input logic [4:0] addr,
                                          input int base,
                                          input int n);
        return (addr != 5'd0) && (int'(addr) >= base) && (int'(addr) < base + n);
    endfunction

endpackage : io_bridge_pkg
`default_nettype wire

// File: rtl/game_io_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : game_io_bridge_if
// Description : Register-file side bus of the game I/O bridge: snooped write
//               port plus the two read ports with their hit flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_io_bridge_if #(
    parameter int DATA_W = 32
) ();

    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [4:0]        ctrl_readRegA;
    logic [4:0]        ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic              hitA;
    logic              hitB;

    // Processor / regfile side
    modport master (
        output ctrl_writeEnable,
        output ctrl_writeReg,
        output data_writeReg,
        output ctrl_readRegA,
        output ctrl_readRegB,
        input  data_readRegA,
        input  data_readRegB,
        input  hitA,
        input  hitB
    );

    // Bridge side
    modport slave (
        input  ctrl_writeEnable,
        input  ctrl_writeReg,
        input  data_writeReg,
        input  ctrl_readRegA,
        input  ctrl_readRegB,
        output data_readRegA,
        output data_readRegB,
        output hitA,
        output hitB
    );

endinterface : game_io_bridge_if
`default_nettype wire

// File: rtl/game_io_bridge_evt_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : evt_sync_edge
// Description : One event channel: two-flop synchroniser followed by a
//               rising-edge detector producing a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module evt_sync_edge (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic evt_async,
    output logic      evt_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the raw level through the synchroniser and the edge history flop
    always_comb begin
        sync1_d = evt_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and edge-history registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // High for the single cycle where the synchronised level has just risen
    assign evt_pulse = sync2_q & ~prev_q;

endmodule : evt_sync_edge
`default_nettype wire

// File: rtl/game_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : game_io_bridge
// Description : Memory-mapped bridge between the processor register file and
//               the game hardware: snapshot input shadows, sticky event flags
//               with overflow and irq, double-buffered frame-commit outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module game_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int NUM_EVT  = 4,
    parameter int NUM_OUT  = 4,
    parameter int DATA_W   = 32,
    parameter int IN_BASE  = c_DEF_IN_BASE,
    parameter int OUT_BASE = c_DEF_OUT_BASE,
    parameter int EVT_REG  = c_DEF_EVT_REG,
    parameter int CTRL_REG = c_DEF_CTRL_REG,
    parameter int AUTO_EVT = 1
) (
    input  wire logic                      clock,
    input  wire logic                      reset,
    game_io_bridge_if.slave                rf,
    input  wire logic [NUM_IN*DATA_W-1:0]  in_data,
    input  wire logic [NUM_EVT-1:0]        evt_in,
    output logic      [NUM_OUT*DATA_W-1:0] out_data,
    output logic                           out_commit,
    output logic                           evt_irq
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0][DATA_W-1:0]  shadow_q,   shadow_d;
    logic [NUM_OUT-1:0][DATA_W-1:0] staging_q,  staging_d;
    logic [NUM_OUT-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_EVT-1:0]             pending_q,  pending_d;
    logic [NUM_EVT-1:0]             overflow_q, overflow_d;
    logic [NUM_EVT-1:0]             mask_q,     mask_d;
    logic                           dirty_q,    dirty_d;
    logic                           out_commit_q, out_commit_d;

    logic [NUM_EVT-1:0] w_evt_edge;
    logic               w_auto;
    logic               w_wr_ctrl;
    logic               w_wr_evt;
    logic               w_snap;
    logic               w_commit;
    logic [NUM_EVT-1:0] w_evt_clr;
    logic [DATA_W:0]    w_rd_a;
    logic [DATA_W:0]    w_rd_b;

    // ------------------------------------------------------------------
    // Event synchronisers
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
            evt_sync_edge u_sync (
                .clock     (clock),
                .reset     (reset),
                .evt_async (evt_in[i]),
                .evt_pulse (w_evt_edge[i])
            );
        end

        if (AUTO_EVT >= 0 && AUTO_EVT < NUM_EVT) begin : g_auto
            assign w_auto = w_evt_edge[AUTO_EVT];
        end else begin : g_no_auto
            assign w_auto = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write decode; processor strobe and auto trigger merge into one action
    // ------------------------------------------------------------------
    assign w_wr_ctrl = rf.ctrl_writeEnable && reg_in_range(rf.ctrl_writeReg, CTRL_REG, 1);
    assign w_wr_evt  = rf.ctrl_writeEnable && reg_in_range(rf.ctrl_writeReg, EVT_REG, 1);
    assign w_snap    = (w_wr_ctrl && rf.data_writeReg[c_CTRL_SNAP])   || w_auto;
    assign w_commit  = (w_wr_ctrl && rf.data_writeReg[c_CTRL_COMMIT]) || w_auto;
    assign w_evt_clr = w_wr_evt ? rf.data_writeReg[NUM_EVT-1:0] : '0;

    // Next-state for shadows, staging, outputs, event flags and control
    always_comb begin
        shadow_d     = shadow_q;
        staging_d    = staging_q;
        out_data_d   = out_data_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        mask_d       = mask_q;
        dirty_d      = dirty_q;
        out_commit_d = w_commit;

        if (w_snap) begin
            shadow_d = in_data;
        end

        // Commit takes the old staging contents; a same-cycle staging write
        // below re-marks the buffer dirty so the new value is not lost
        if (w_commit) begin
            out_data_d = staging_q;
            dirty_d    = 1'b0;
        end

        for (int k = 0; k < NUM_OUT; k++) begin
            if (rf.ctrl_writeEnable && reg_in_range(rf.ctrl_writeReg, OUT_BASE + k, 1)) begin
                staging_d[k] = rf.data_writeReg;
                dirty_d      = 1'b1;
            end
        end

        if (w_wr_ctrl) begin
            mask_d = rf.data_writeReg[c_CTRL_MASK_LSB +: NUM_EVT];
        end

        // A new edge beats a clear on pending; a clear always wipes overflow
        for (int i = 0; i < NUM_EVT; i++) begin
            pending_d[i]  = w_evt_edge[i] | (pending_q[i] & ~w_evt_clr[i]);
            overflow_d[i] = w_evt_clr[i] ? 1'b0
                                         : (overflow_q[i] | (w_evt_edge[i] & pending_q[i]));
        end
    end

    // Bridge state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q     <= '0;
            staging_q    <= '0;
            out_data_q   <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            mask_q       <= '0;
            dirty_q      <= 1'b0;
            out_commit_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            staging_q    <= staging_d;
            out_data_q   <= out_data_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            mask_q       <= mask_d;
            dirty_q      <= dirty_d;
            out_commit_q <= out_commit_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: {hit, data}, purely from registered state
    // ------------------------------------------------------------------
    function automatic logic [DATA_W:0] read_mux(input logic [4:0] addr);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (reg_in_range(addr, IN_BASE + k, 1)) begin
                r = {1'b1, shadow_q[k]};
            end
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (reg_in_range(addr, OUT_BASE + k, 1)) begin
                r = {1'b1, staging_q[k]};
            end
        end
        if (reg_in_range(addr, EVT_REG, 1)) begin
            r[DATA_W]                       = 1'b1;
            r[NUM_EVT-1:0]                  = pending_q;
            r[c_EVT_OVF_LSB +: NUM_EVT]     = overflow_q;
        end
        if (reg_in_range(addr, CTRL_REG, 1)) begin
            r[DATA_W]                       = 1'b1;
            r[c_CTRL_DIRTY]                 = dirty_q;
            r[c_CTRL_MASK_LSB +: NUM_EVT]   = mask_q;
        end
        return r;
    endfunction

    assign w_rd_a = read_mux(rf.ctrl_readRegA);
    assign w_rd_b = read_mux(rf.ctrl_readRegB);

    assign rf.data_readRegA = w_rd_a[DATA_W-1:0];
    assign rf.hitA          = w_rd_a[DATA_W];
    assign rf.data_readRegB = w_rd_b[DATA_W-1:0];
    assign rf.hitB          = w_rd_b[DATA_W];

    assign out_data   = out_data_q;
    assign out_commit = out_commit_q;
    assign evt_irq    = |(pending_q & mask_q);

endmodule : game_io_bridge
`default_nettype wire

// File: tb/tb_game_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_io_bridge
// Description : Directed self-checking bench for game_io_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_io_bridge;

    localparam int DATA_W  = 32;
    localparam int NUM_IN  = 4;
    localparam int NUM_EVT = 4;
    localparam int NUM_OUT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_EVT-1:0]        evt_in;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic                      out_commit;
    logic                      evt_irq;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    game_io_bridge_if #(.DATA_W(DATA_W)) bus ();

    game_io_bridge #(
        .NUM_IN   (NUM_IN),
        .NUM_EVT  (NUM_EVT),
        .NUM_OUT  (NUM_OUT),
        .DATA_W   (DATA_W),
        .IN_BASE  (20),
        .OUT_BASE (14),
        .EVT_REG  (24),
        .CTRL_REG (25),
        .AUTO_EVT (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rf         (bus.slave),
        .in_data    (in_data),
        .evt_in     (evt_in),
        .out_data   (out_data),
        .out_commit (out_commit),
        .evt_irq    (evt_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = r;
        bus.data_writeReg    = d;
        tick();
        bus.ctrl_writeEnable = 1'b0;
    endtask

    // Read through both ports, checking data on each and hit on port A
    task automatic rd(input string tag, input logic [4:0] r, input logic [31:0] exp);
        bus.ctrl_readRegA = r;
        bus.ctrl_readRegB = r;
        #1;
        check_eq({tag, "_a"}, bus.data_readRegA, exp);
        check_eq({tag, "_b"}, bus.data_readRegB, exp);
        check_eq({tag, "_hit"}, {31'b0, bus.hitA}, 32'd1);
    endtask

    function automatic logic [NUM_IN*DATA_W-1:0] frame(input int i);
        logic [NUM_IN*DATA_W-1:0] f;
        for (int k = 0; k < NUM_IN; k++) begin
            f[k*DATA_W +: DATA_W] = 32'(32'h1000_0000 * (k + 1) + i);
        end
        return f;
    endfunction

    function automatic logic [31:0] out_word(input int k);
        return out_data[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        logic [NUM_IN*DATA_W-1:0] snap_frame;
        logic [NUM_IN*DATA_W-1:0] auto_frame;

        in_data              = '0;
        evt_in               = '0;
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = 5'd0;
        bus.data_writeReg    = '0;
        bus.ctrl_readRegA    = 5'd0;
        bus.ctrl_readRegB    = 5'd0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int r = 20; r <= 25; r++) begin
            rd($sformatf("reset_r%0d", r), 5'(r), 32'h0);
        end
        bus.ctrl_readRegA = 5'd5;
        #1;
        check_eq("unmapped_hit", {31'b0, bus.hitA}, 32'd0);
        check_eq("unmapped_data", bus.data_readRegA, 32'h0);
        check_eq("reset_commit", {31'b0, out_commit}, 32'd0);
        check_eq("reset_irq", {31'b0, evt_irq}, 32'd0);
        check_eq("reset_out", out_data[31:0], 32'h0);

        // Single button pulse with mask=0x1: visible after edge N+2
        wr(5'd25, 32'h0000_0100);
        evt_in[0] = 1'b1;
        tick();                         // edge N samples the pulse
        evt_in[0] = 1'b0;
        tick();                         // edge N+1
        rd("evt_latency", 5'd24, 32'h0);
        tick();                         // edge N+2
        rd("evt_set", 5'd24, 32'h1);
        check_eq("irq_set", {31'b0, evt_irq}, 32'd1);
        wr(5'd24, 32'h1);
        rd("evt_clr", 5'd24, 32'h0);
        check_eq("irq_clr", {31'b0, evt_irq}, 32'd0);

        // Two pulses without clear -> overflow; clear coincident with third edge
        evt_in[0] = 1'b1; tick(); evt_in[0] = 1'b0; repeat (3) tick();
        evt_in[0] = 1'b1; tick(); evt_in[0] = 1'b0; repeat (3) tick();
        rd("evt_ovf", 5'd24, 32'h0001_0001);
        evt_in[0] = 1'b1; tick(); evt_in[0] = 1'b0; tick();
        wr(5'd24, 32'h1);               // lands on the third edge's set cycle
        rd("evt_edge_wins", 5'd24, 32'h0000_0001);
        wr(5'd24, 32'h1);
        rd("evt_clr2", 5'd24, 32'h0);

        // Double-buffered outputs
        wr(5'd14, 32'h0000_AAAA);
        wr(5'd15, 32'h0000_5555);
        check_eq("stage_out0", out_word(0), 32'h0);
        check_eq("stage_out1", out_word(1), 32'h0);
        rd("stage_r14", 5'd14, 32'h0000_AAAA);
        rd("dirty_set", 5'd25, 32'h0000_0104);
        wr(5'd25, 32'h2);
        check_eq("commit_out0", out_word(0), 32'h0000_AAAA);
        check_eq("commit_out1", out_word(1), 32'h0000_5555);
        check_eq("commit_pulse", {31'b0, out_commit}, 32'd1);
        rd("dirty_clr", 5'd25, 32'h0);
        tick();
        check_eq("commit_pulse_end", {31'b0, out_commit}, 32'd0);

        // Snapshot while in_data changes every cycle
        for (int i = 0; i < 4; i++) begin
            in_data = frame(i);
            tick();
        end
        snap_frame           = frame(10);
        in_data              = snap_frame;
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd25;
        bus.data_writeReg    = 32'h1;
        bus.ctrl_readRegB    = 5'd20;
        #1;
        check_eq("snap_pre_read", bus.data_readRegB, 32'h0);
        tick();
        bus.ctrl_writeEnable = 1'b0;
        in_data = frame(11);
        for (int k = 0; k < NUM_IN; k++) begin
            rd($sformatf("snap_r%0d", 20 + k), 5'(20 + k), snap_frame[k*DATA_W +: DATA_W]);
        end
        tick();
        in_data = frame(12);
        rd("snap_hold", 5'd23, snap_frame[3*DATA_W +: DATA_W]);

        // Auto trigger on screen event coinciding with a staging write
        wr(5'd16, 32'h0000_0033);
        wr(5'd25, 32'h2);
        check_eq("pre_auto_out2", out_word(2), 32'h0000_0033);
        tick();
        evt_in[1] = 1'b1; tick(); evt_in[1] = 1'b0; tick();
        auto_frame = frame(20);
        in_data    = auto_frame;
        wr(5'd16, 32'h7);               // same edge as the auto snapshot+commit
        check_eq("auto_out2", out_word(2), 32'h0000_0033);
        check_eq("auto_pulse", {31'b0, out_commit}, 32'd1);
        rd("auto_r16", 5'd16, 32'h7);
        rd("auto_dirty", 5'd25, 32'h4);
        rd("auto_snap", 5'd20, auto_frame[31:0]);
        rd("auto_evt", 5'd24, 32'h2);
        tick();
        check_eq("auto_pulse_end", {31'b0, out_commit}, 32'd0);

        // Reset mid-operation drops staging, events and outputs
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_out2", out_word(2), 32'h0);
        rd("rst_r16", 5'd16, 32'h0);
        rd("rst_evt", 5'd24, 32'h0);
        rd("rst_ctrl", 5'd25, 32'h0);
        rd("rst_r20", 5'd20, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_game_io_bridge
`default_nettype wire
